// File: rtl/oam_controller.sv
// OAM responder: 160-byte sprite table at FE00-FE9F serving DMA, CPU and PPU ports.
// Optional macro OAM_PPU_LOCK_EN also blocks CPU access while ppu_mode is 2 or 3.
module oam_controller (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        DmaEnableSignal,
  input  logic [15:0] A_dma,
  input  logic [7:0]  Di_dma,
  input  logic        wr_dma,
  input  logic        rd_dma,
  output logic [7:0]  Do_dma,
  input  logic [15:0] A_cpu,
  input  logic [7:0]  Di_cpu,
  input  logic        wr_cpu,
  input  logic        rd_cpu,
  output logic [7:0]  Do_cpu,
  input  logic [1:0]  ppu_mode,
  input  logic        rd_ppu,
  input  logic [5:0]  A_ppu,
  output logic [15:0] Do_ppu,
  output logic        dma_done
);

  typedef enum logic [1:0] {DEC_ARRAY, DEC_HOLE, DEC_NONE} dec_e;

  function automatic dec_e decode(input logic [15:0] a);
    if (a[15:8] != 8'hFE) return DEC_NONE;
    if (a[7:0] < 8'hA0)   return DEC_ARRAY;
    return DEC_HOLE;
  endfunction

  logic [7:0]  mem_q [160];

  logic        wr_dma_prev_q, wr_dma_prev_d;
  logic        wr_cpu_prev_q, wr_cpu_prev_d;
  logic        en_prev_q, en_prev_d;
  logic [7:0]  dma_count_q, dma_count_d;
  logic        dma_done_q, dma_done_d;
  logic [7:0]  do_dma_q, do_dma_d;
  logic [7:0]  do_cpu_q, do_cpu_d;
  logic [15:0] do_ppu_q, do_ppu_d;

  logic        cpu_block;
  logic        dma_accept, cpu_accept;
  logic        mem_we;
  logic [7:0]  mem_waddr, mem_wdata;
  logic [7:0]  count_base;

`ifdef OAM_PPU_LOCK_EN
  assign cpu_block = DmaEnableSignal | ppu_mode[1];
`else
  logic unused_ppu_mode;
  assign unused_ppu_mode = ^ppu_mode;
  assign cpu_block = DmaEnableSignal;
`endif

  always_comb begin
    wr_dma_prev_d = wr_dma;
    wr_cpu_prev_d = wr_cpu;
    en_prev_d     = DmaEnableSignal;
    do_dma_d      = do_dma_q;
    do_cpu_d      = do_cpu_q;
    do_ppu_d      = do_ppu_q;
    mem_we        = 1'b0;
    mem_waddr     = '0;
    mem_wdata     = '0;
    dma_done_d    = 1'b0;

    dma_accept = reset_n & wr_dma & ~wr_dma_prev_q & DmaEnableSignal
               & (decode(A_dma) == DEC_ARRAY);
    cpu_accept = reset_n & wr_cpu & ~wr_cpu_prev_q & ~cpu_block
               & (decode(A_cpu) == DEC_ARRAY);

    // DMA owns the single write port; CPU is blocked whenever DMA is enabled anyway
    if (dma_accept) begin
      mem_we    = 1'b1;
      mem_waddr = A_dma[7:0];
      mem_wdata = Di_dma;
    end else if (cpu_accept) begin
      mem_we    = 1'b1;
      mem_waddr = A_cpu[7:0];
      mem_wdata = Di_cpu;
    end

    count_base  = (DmaEnableSignal && !en_prev_q) ? '0 : dma_count_q;
    dma_count_d = count_base;
    if (dma_accept) begin
      if (count_base == 8'd159) begin
        dma_count_d = '0;
        dma_done_d  = 1'b1;
      end else begin
        dma_count_d = count_base + 8'd1;
      end
    end

    if (rd_dma) begin
      unique case (decode(A_dma))
        DEC_ARRAY: do_dma_d = mem_q[A_dma[7:0]];
        DEC_HOLE:  do_dma_d = '0;
        default:   do_dma_d = '1;
      endcase
    end

    if (rd_cpu) begin
      if (cpu_block) begin
        do_cpu_d = '1;
      end else begin
        unique case (decode(A_cpu))
          DEC_ARRAY: do_cpu_d = mem_q[A_cpu[7:0]];
          DEC_HOLE:  do_cpu_d = '0;
          default:   do_cpu_d = '1;
        endcase
      end
    end

    if (rd_ppu) begin
      if (A_ppu < 6'd40) do_ppu_d = {mem_q[{A_ppu, 2'b01}], mem_q[{A_ppu, 2'b00}]};
      else               do_ppu_d = '1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      // Edge registers track the live strobe during reset so a level held across release is not an edge
      wr_dma_prev_q <= wr_dma;
      wr_cpu_prev_q <= wr_cpu;
      en_prev_q     <= DmaEnableSignal;
      dma_count_q   <= '0;
      dma_done_q    <= 1'b0;
      do_dma_q      <= '0;
      do_cpu_q      <= '1;
      do_ppu_q      <= '1;
    end else begin
      wr_dma_prev_q <= wr_dma_prev_d;
      wr_cpu_prev_q <= wr_cpu_prev_d;
      en_prev_q     <= en_prev_d;
      dma_count_q   <= dma_count_d;
      dma_done_q    <= dma_done_d;
      do_dma_q      <= do_dma_d;
      do_cpu_q      <= do_cpu_d;
      do_ppu_q      <= do_ppu_d;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign Do_dma   = do_dma_q;
  assign Do_cpu   = do_cpu_q;
  assign Do_ppu   = do_ppu_q;
  assign dma_done = dma_done_q;

endmodule
